unidade_controle_jogo: RTL and testbench

Moore control unit that sequences the ultimate tic-tac-toe datapath: clears the edge detector and the macro/micro registers, captures macro (board) and micro (cell) choices from button pulses, forwards the played cell as the next macro board, and toggles the current player. It sits beside the datapath, consuming `tem_jogada`, `escolhe_macro` and `fim_jogo` and driving every clear, enable and mux-select line.

---
 rtl/jogo_pkg.sv | 44 ++++
 rtl/unidade_controle_jogo_if.sv | 44 ++++
 rtl/contador_timeout.sv | 36 +++
 rtl/unidade_controle_jogo.sv | 127 ++++++++++++
 tb/tb_unidade_controle_jogo.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// ============================================================================
// jogo_pkg : state codes, player encoding and timeout default for the
//            ultimate tic-tac-toe control unit.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package jogo_pkg;

    localparam logic [3:0] c_ST_INICIAL        = 4'd0;
    localparam logic [3:0] c_ST_PREPARACAO     = 4'd1;
    localparam logic [3:0] c_ST_ESPERA_MACRO   = 4'd2;
    localparam logic [3:0] c_ST_REGISTRA_MACRO = 4'd3;
    localparam logic [3:0] c_ST_ESPERA_MICRO   = 4'd4;
    localparam logic [3:0] c_ST_REGISTRA_MICRO = 4'd5;
    localparam logic [3:0] c_ST_VERIFICA       = 4'd6;
    localparam logic [3:0] c_ST_DECIDE         = 4'd7;
    localparam logic [3:0] c_ST_ATUALIZA_MACRO = 4'd8;
    localparam logic [3:0] c_ST_FIM            = 4'd9;
    localparam logic [3:0] c_ST_TIMEOUT        = 4'd10;

    localparam int TIMEOUT_CICLOS = 5000;

    localparam logic JOGADOR_X = 1'b0;
    localparam logic JOGADOR_O = 1'b1;

    typedef enum logic [3:0] {
        INICIAL        = c_ST_INICIAL,
        PREPARACAO     = c_ST_PREPARACAO,
        ESPERA_MACRO   = c_ST_ESPERA_MACRO,
        REGISTRA_MACRO = c_ST_REGISTRA_MACRO,
        ESPERA_MICRO   = c_ST_ESPERA_MICRO,
        REGISTRA_MICRO = c_ST_REGISTRA_MICRO,
        VERIFICA       = c_ST_VERIFICA,
        DECIDE         = c_ST_DECIDE,
        ATUALIZA_MACRO = c_ST_ATUALIZA_MACRO,
        FIM            = c_ST_FIM,
        TIMEOUT        = c_ST_TIMEOUT
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/unidade_controle_jogo_if.sv
// ============================================================================
// unidade_controle_jogo_if : status inputs and strobe/select outputs between
//                            the game datapath and its control unit.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface unidade_controle_jogo_if;

    logic       jogar;
    logic       tem_jogada;
    logic       escolhe_macro;
    logic       fim_jogo;
    logic       zeraEdge;
    logic       zeraR_micro;
    logic       zeraR_macro;
    logic       registraR_micro;
    logic       registraR_macro;
    logic       sinal_macro;
    logic       jogador;
    logic       pronto;
    logic       timeout;
    logic [3:0] db_estado;

    // Datapath / stimulus side
    modport master (
        output jogar, tem_jogada, escolhe_macro, fim_jogo,
        input  zeraEdge, zeraR_micro, zeraR_macro, registraR_micro,
               registraR_macro, sinal_macro, jogador, pronto, timeout,
               db_estado
    );

    // Control unit side
    modport slave (
        input  jogar, tem_jogada, escolhe_macro, fim_jogo,
        output zeraEdge, zeraR_micro, zeraR_macro, registraR_micro,
               registraR_macro, sinal_macro, jogador, pronto, timeout,
               db_estado
    );

endinterface

`default_nettype wire

// File: rtl/contador_timeout.sv
// ============================================================================
// contador_timeout : idle-cycle counter with clear, enable and terminal count
//                    (terminal value CICLOS-1).
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module contador_timeout #(
    parameter int CICLOS = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_fim
);

    localparam int                c_LARG     = (CICLOS > 2) ? $clog2(CICLOS) : 1;
    localparam logic [c_LARG-1:0] c_TERMINAL = c_LARG'(CICLOS - 1);

    logic [c_LARG-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_fim = (r_cnt == c_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/unidade_controle_jogo.sv
// ============================================================================
// unidade_controle_jogo : Moore control unit for the ultimate tic-tac-toe
//                         datapath. Optional wait-state timeout: JOGADA_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = jogo_pkg::TIMEOUT_CICLOS
) (
    input  wire logic              clock,
    input  wire logic              reset,
    unidade_controle_jogo_if.slave sinais
);

    estado_t r_estado;
    estado_t w_prox;
    logic    r_jogador;
    logic    w_fim_espera;
    logic    w_em_espera;

    assign w_em_espera = (r_estado == ESPERA_MACRO) || (r_estado == ESPERA_MICRO);

`ifdef JOGADA_TIMEOUT_EN
    logic w_clr_cnt;

    // Counter restarts on any state change so each wait gets a full budget
    assign w_clr_cnt = !w_em_espera || (w_prox != r_estado);

    contador_timeout #(
        .CICLOS (TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clk   (clock),
        .rst   (reset),
        .i_clr (w_clr_cnt),
        .i_en  (w_em_espera),
        .o_fim (w_fim_espera)
    );
`else
    assign w_fim_espera = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL, FIM, TIMEOUT: begin
                if (sinais.jogar) w_prox = PREPARACAO;
            end
            PREPARACAO:     w_prox = ESPERA_MACRO;
            ESPERA_MACRO: begin
                if (sinais.tem_jogada)  w_prox = REGISTRA_MACRO;
                else if (w_fim_espera)  w_prox = TIMEOUT;
            end
            REGISTRA_MACRO: w_prox = ESPERA_MICRO;
            ESPERA_MICRO: begin
                if (sinais.tem_jogada)  w_prox = REGISTRA_MICRO;
                else if (w_fim_espera)  w_prox = TIMEOUT;
            end
            REGISTRA_MICRO: w_prox = VERIFICA;
            VERIFICA:       w_prox = DECIDE;
            DECIDE: begin
                if (sinais.fim_jogo)           w_prox = FIM;
                else if (sinais.escolhe_macro) w_prox = ESPERA_MACRO;
                else                           w_prox = ATUALIZA_MACRO;
            end
            ATUALIZA_MACRO: w_prox = ESPERA_MICRO;
            default:        w_prox = INICIAL;
        endcase
    end

    // On game over the player is held so it names the last mover
    always_ff @(posedge clock) begin
        if (reset || (r_estado == PREPARACAO)) begin
            r_jogador <= JOGADOR_X;
        end else if ((r_estado == DECIDE) && !sinais.fim_jogo) begin
            r_jogador <= ~r_jogador;
        end
    end

    always_comb begin
        sinais.zeraEdge        = 1'b0;
        sinais.zeraR_micro     = 1'b0;
        sinais.zeraR_macro     = 1'b0;
        sinais.registraR_micro = 1'b0;
        sinais.registraR_macro = 1'b0;
        sinais.sinal_macro     = 1'b0;
        sinais.pronto          = 1'b0;
        case (r_estado)
            PREPARACAO: begin
                sinais.zeraEdge    = 1'b1;
                sinais.zeraR_micro = 1'b1;
                sinais.zeraR_macro = 1'b1;
            end
            REGISTRA_MACRO: begin
                sinais.registraR_macro = 1'b1;
                sinais.sinal_macro     = 1'b1;
            end
            REGISTRA_MICRO: sinais.registraR_micro = 1'b1;
            ATUALIZA_MACRO: sinais.registraR_macro = 1'b1;
            FIM:            sinais.pronto          = 1'b1;
            default: ;
        endcase
    end

`ifdef JOGADA_TIMEOUT_EN
    assign sinais.timeout = (r_estado == TIMEOUT);
`else
    assign sinais.timeout = 1'b0;
`endif

    assign sinais.jogador   = r_jogador;
    assign sinais.db_estado = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle_jogo.sv
// ============================================================================
// tb_unidade_controle_jogo : directed stimulus with a queued-expectation
//                            scoreboard for unidade_controle_jogo.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_unidade_controle_jogo;

    typedef struct {
        string      nome;
        logic [3:0] est;
        logic [7:0] sai;
        logic       jog;
    } esperado_t;

    // Output vector bit order:
    // zeraEdge zeraR_micro zeraR_macro registraR_micro registraR_macro sinal_macro pronto timeout
    localparam logic [7:0] c_NADA  = 8'b0000_0000;
    localparam logic [7:0] c_PREP  = 8'b1110_0000;
    localparam logic [7:0] c_RMAC  = 8'b0000_1100;
    localparam logic [7:0] c_RMIC  = 8'b0001_0000;
    localparam logic [7:0] c_ATUA  = 8'b0000_1000;
    localparam logic [7:0] c_PRONT = 8'b0000_0010;
    localparam logic [7:0] c_TOUT  = 8'b0000_0001;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    esperado_t fila[$];

    unidade_controle_jogo_if bus ();

    unidade_controle_jogo #(
        .TIMEOUT_CICLOS (8)
    ) dut (
        .clock  (clk),
        .reset  (rst),
        .sinais (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the control unit presents a new output word every cycle
    always @(negedge clk) begin
        if (fila.size() > 0) begin
            esperado_t e;
            logic [7:0] sai;
            e   = fila.pop_front();
            sai = {bus.zeraEdge, bus.zeraR_micro, bus.zeraR_macro, bus.registraR_micro,
                   bus.registraR_macro, bus.sinal_macro, bus.pronto, bus.timeout};
            checks++;
            if (bus.db_estado !== e.est || sai !== e.sai || bus.jogador !== e.jog) begin
                errors++;
                $display("FAIL %s: got estado=%0d saidas=%b jogador=%b, want estado=%0d saidas=%b jogador=%b",
                         e.nome, bus.db_estado, sai, bus.jogador, e.est, e.sai, e.jog);
            end
        end
    end

    task automatic cyc(input string nome, input logic r, input logic j, input logic t,
                       input logic esc, input logic fim,
                       input logic [3:0] est, input logic [7:0] sai, input logic jog);
        esperado_t e;
        rst               = r;
        bus.jogar         = j;
        bus.tem_jogada    = t;
        bus.escolhe_macro = esc;
        bus.fim_jogo      = fim;
        @(posedge clk);
        e.nome = nome; e.est = est; e.sai = sai; e.jog = jog;
        fila.push_back(e);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.jogar = 1'b0; bus.tem_jogada = 1'b0; bus.escolhe_macro = 1'b0; bus.fim_jogo = 1'b0;
        @(posedge clk);
        #1;

        //   name            rst jog tem esc fim  est  outputs  jogador
        cyc("reset",          1,  0,  0,  0,  0,  0,   c_NADA,  0);
        cyc("inicial_hold",   0,  0,  0,  0,  0,  0,   c_NADA,  0);
        cyc("preparacao",     0,  1,  0,  0,  0,  1,   c_PREP,  0);
        cyc("espera_macro",   0,  0,  0,  0,  0,  2,   c_NADA,  0);
        cyc("jogar_ignorado", 0,  1,  0,  0,  0,  2,   c_NADA,  0);
        cyc("reg_macro",      0,  0,  1,  0,  0,  3,   c_RMAC,  0);
        cyc("espera_micro",   0,  0,  0,  0,  0,  4,   c_NADA,  0);
        cyc("reg_micro",      0,  0,  1,  0,  0,  5,   c_RMIC,  0);
        cyc("verifica",       0,  0,  1,  0,  0,  6,   c_NADA,  0);
        cyc("decide",         0,  0,  0,  0,  0,  7,   c_NADA,  0);
        cyc("atualiza_macro", 0,  0,  0,  0,  0,  8,   c_ATUA,  1);
        cyc("volta_micro",    0,  0,  1,  0,  0,  4,   c_NADA,  1);
        cyc("pulso_perdido",  0,  0,  0,  0,  0,  4,   c_NADA,  1);
        // escolhe_macro round: back to board choice, player toggles to X
        cyc("reg_micro2",     0,  0,  1,  0,  0,  5,   c_RMIC,  1);
        cyc("verifica2",      0,  0,  0,  0,  0,  6,   c_NADA,  1);
        cyc("decide2",        0,  0,  0,  0,  0,  7,   c_NADA,  1);
        cyc("escolhe_macro",  0,  0,  0,  1,  0,  2,   c_NADA,  0);
        cyc("reg_macro3",     0,  0,  1,  0,  0,  3,   c_RMAC,  0);
        cyc("espera_micro3",  0,  0,  0,  0,  0,  4,   c_NADA,  0);
        cyc("reg_micro3",     0,  0,  1,  0,  0,  5,   c_RMIC,  0);
        cyc("verifica3",      0,  0,  0,  0,  0,  6,   c_NADA,  0);
        cyc("decide3",        0,  0,  0,  0,  0,  7,   c_NADA,  0);
        cyc("atualiza3",      0,  0,  0,  0,  0,  8,   c_ATUA,  1);
        cyc("espera_micro4",  0,  0,  0,  0,  0,  4,   c_NADA,  1);
        // fim_jogo beats escolhe_macro; O made the last move
        cyc("reg_micro4",     0,  0,  1,  0,  0,  5,   c_RMIC,  1);
        cyc("verifica4",      0,  0,  0,  0,  0,  6,   c_NADA,  1);
        cyc("decide4",        0,  0,  0,  1,  1,  7,   c_NADA,  1);
        cyc("fim",            0,  0,  0,  1,  1,  9,   c_PRONT, 1);
        cyc("fim_hold",       0,  0,  1,  0,  0,  9,   c_PRONT, 1);
        cyc("reinicio",       0,  1,  0,  0,  0,  1,   c_PREP,  1);
        cyc("espera_macro5",  0,  0,  0,  0,  0,  2,   c_NADA,  0);
        // mid-game reset with O to move
        cyc("reg_macro5",     0,  0,  1,  0,  0,  3,   c_RMAC,  0);
        cyc("espera_micro5",  0,  0,  0,  0,  0,  4,   c_NADA,  0);
        cyc("reg_micro5",     0,  0,  1,  0,  0,  5,   c_RMIC,  0);
        cyc("verifica5",      0,  0,  0,  0,  0,  6,   c_NADA,  0);
        cyc("decide5",        0,  0,  0,  1,  0,  7,   c_NADA,  0);
        cyc("espera_macro6",  0,  0,  0,  1,  0,  2,   c_NADA,  1);
        cyc("reg_macro6",     0,  0,  1,  0,  0,  3,   c_RMAC,  1);
        cyc("espera_micro6",  0,  0,  0,  0,  0,  4,   c_NADA,  1);
        cyc("reg_micro6",     0,  0,  1,  0,  0,  5,   c_RMIC,  1);
        cyc("reset_meio",     1,  1,  1,  1,  1,  0,   c_NADA,  0);
        cyc("pos_reset",      0,  0,  0,  0,  0,  0,   c_NADA,  0);

        // Wait-state idling: timeout when enabled, indefinite hold otherwise
        cyc("prep_t",         0,  1,  0,  0,  0,  1,   c_PREP,  0);
        cyc("espera_t",       0,  0,  0,  0,  0,  2,   c_NADA,  0);
        cyc("reg_macro_t",    0,  0,  1,  0,  0,  3,   c_RMAC,  0);
        cyc("entra_micro_t",  0,  0,  0,  0,  0,  4,   c_NADA,  0);
        for (int i = 0; i < 7; i++) begin
            cyc("idle_micro", 0,  0,  0,  0,  0,  4,   c_NADA,  0);
        end
`ifdef JOGADA_TIMEOUT_EN
        cyc("timeout",        0,  0,  0,  0,  0,  10,  c_TOUT,  0);
        cyc("timeout_hold",   0,  0,  1,  0,  0,  10,  c_TOUT,  0);
        cyc("prep_t2",        0,  1,  0,  0,  0,  1,   c_PREP,  0);
        cyc("espera_t2",      0,  0,  0,  0,  0,  2,   c_NADA,  0);
        cyc("reg_macro_t2",   0,  0,  1,  0,  0,  3,   c_RMAC,  0);
        cyc("entra_micro_t2", 0,  0,  0,  0,  0,  4,   c_NADA,  0);
        for (int i = 0; i < 7; i++) begin
            cyc("idle_micro2", 0, 0,  0,  0,  0,  4,   c_NADA,  0);
        end
        cyc("jogada_limite",  0,  0,  1,  0,  0,  5,   c_RMIC,  0);
`else
        for (int i = 0; i < 6; i++) begin
            cyc("sem_timeout", 0, 0,  0,  0,  0,  4,   c_NADA,  0);
        end
        cyc("jogada_tardia",  0,  0,  1,  0,  0,  5,   c_RMIC,  0);
`endif
        cyc("verifica_fim",   0,  0,  0,  0,  0,  6,   c_NADA,  0);

        for (int k = 0; k < 10 && fila.size() > 0; k++) begin
            @(posedge clk);
        end
        if (fila.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", fila.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
